// File: rtl/load_store_unit.sv
// Memory execution stage: one load/store at a time, word memory with single-cycle
// sub-word read-modify-write, result broadcast on the CDB. Optional: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int unsigned TAG_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        iss_valid,
  output logic                        iss_ready,
  input  logic                        iss_store,
  input  logic [2:0]                  iss_funct3,
  input  logic [31:0]                 iss_base,
  input  logic [31:0]                 iss_imm,
  input  logic [31:0]                 iss_data,
  input  logic [TAG_W-1:0]            iss_tag,
  output logic [$clog2(MEM_SIZE)-1:0] mem_add,
  output logic                        mem_we,
  output logic [31:0]                 mem_dw,
  input  logic [31:0]                 mem_dr,
  output logic                        cdb_valid,
  input  logic                        cdb_ready,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [31:0]                 cdb_data,
  output logic                        cdb_exc
);

  localparam int unsigned ADDR_W = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [31:0]       r_data;
  logic [TAG_W-1:0]  r_tag;
  logic [ADDR_W-1:0] r_ea;
  logic [31:0]       r_mem_dw;
  logic [31:0]       r_cdb_data;
  logic              r_cdb_exc;

  logic [31:0]       w_ea;
  logic              w_unused_ea;
  logic              w_accept;
  logic              w_we;
  logic              w_mis;
  logic [31:0]       w_rd_b;
  logic [31:0]       w_rd_h;
  logic [31:0]       w_ld;
  logic [31:0]       w_dw;
  logic [31:0]       w_mask;

  assign w_ea        = iss_base + iss_imm;
  assign w_unused_ea = ^w_ea[31:ADDR_W];
  assign iss_ready   = (r_state == S_IDLE) && !flush;
  assign w_accept    = iss_valid && iss_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = ((r_funct3[1:0] == 2'b01) && r_ea[0]) || (r_funct3[1] && (r_ea[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  // Lane extraction for loads; halves use ea[1] only, so misaligned halves align down.
  assign w_rd_b = mem_dr >> {r_ea[1:0], 3'b000};
  assign w_rd_h = mem_dr >> {r_ea[1], 4'b0000};

  always_comb begin
    w_ld = mem_dr;
    case (r_funct3)
      3'b000:  w_ld = {{24{w_rd_b[7]}}, w_rd_b[7:0]};
      3'b001:  w_ld = {{16{w_rd_h[15]}}, w_rd_h[15:0]};
      3'b100:  w_ld = {24'h000000, w_rd_b[7:0]};
      3'b101:  w_ld = {16'h0000, w_rd_h[15:0]};
      default: w_ld = mem_dr;
    endcase
  end

  // Store word: sub-word stores merge the addressed lane into the current memory word.
  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    w_dw   = r_data;
    case (r_funct3[1:0])
      2'b00: begin
        w_mask = 32'h0000_00FF << {r_ea[1:0], 3'b000};
        w_dw   = (mem_dr & ~w_mask) | ({4{r_data[7:0]}} & w_mask);
      end
      2'b01: begin
        w_mask = 32'h0000_FFFF << {r_ea[1], 4'b0000};
        w_dw   = (mem_dr & ~w_mask) | ({2{r_data[15:0]}} & w_mask);
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        w_dw   = r_data;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_EXEC;
      S_EXEC: begin
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          w_we   = r_store && !w_mis;
          w_next = S_RESP;
        end
      end
      S_RESP: if (cdb_ready || flush) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_store    <= 1'b0;
      r_funct3   <= 3'b000;
      r_data     <= 32'h0;
      r_tag      <= '0;
      r_ea       <= '0;
      r_mem_dw   <= 32'h0;
      r_cdb_data <= 32'h0;
      r_cdb_exc  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store  <= iss_store;
        r_funct3 <= iss_funct3;
        r_data   <= iss_data;
        r_tag    <= iss_tag;
        r_ea     <= w_ea[ADDR_W-1:0];
      end
      if ((r_state == S_EXEC) && !flush) begin
        r_cdb_data <= (r_store || w_mis) ? 32'h0 : w_ld;
        r_cdb_exc  <= w_mis;
        if (w_we) r_mem_dw <= w_dw;
      end
    end
  end

  assign mem_add   = r_ea;
  assign mem_we    = w_we;
  assign mem_dw    = w_we ? w_dw : r_mem_dw;
  assign cdb_valid = (r_state == S_RESP);
  assign cdb_tag   = r_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_exc   = r_cdb_exc;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a result scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  logic        iss_store = 1'b0;
  logic [2:0]  iss_funct3 = 3'b000;
  logic [31:0] iss_base = 32'h0;
  logic [31:0] iss_imm = 32'h0;
  logic [31:0] iss_data = 32'h0;
  logic [3:0]  iss_tag = 4'h0;
  logic [9:0]  mem_add;
  logic        mem_we;
  logic [31:0] mem_dw;
  logic [31:0] mem_dr;
  logic        cdb_valid;
  logic        cdb_ready = 1'b0;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_exc;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [256];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_SIZE(1024), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_store(iss_store),
    .iss_funct3(iss_funct3), .iss_base(iss_base), .iss_imm(iss_imm),
    .iss_data(iss_data), .iss_tag(iss_tag),
    .mem_add(mem_add), .mem_we(mem_we), .mem_dw(mem_dw), .mem_dr(mem_dr),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_exc(cdb_exc)
  );

  assign mem_dr = mem[mem_add[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_add[9:2]] <= mem_dw;
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] data, input logic [3:0] tag,
                        input logic [31:0] exp_d, input logic exp_x, input int exp_we,
                        input int hold);
    exp_t e;
    int   we_cnt;
    int   lat;
    sb.push_back({tag, exp_d, exp_x});
    @(negedge clk);
    chk("iss_ready_idle", 32'(iss_ready), 32'd1);
    iss_valid = 1'b1; iss_store = st; iss_funct3 = f3;
    iss_base = base; iss_imm = imm; iss_data = data; iss_tag = tag;
    @(posedge clk);
    #1 iss_valid = 1'b0;
    we_cnt = 0;
    lat = 0;
    while (!cdb_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_we) we_cnt++;
    end
    chk("latency", 32'(lat), 32'd2);
    chk("mem_we_cycles", 32'(we_cnt), 32'(exp_we));
    e = sb.pop_front();
    chk("cdb_tag", 32'(cdb_tag), 32'(e.tag));
    chk("cdb_data", cdb_data, e.data);
    chk("cdb_exc", 32'(cdb_exc), 32'(e.exc));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(cdb_valid), 32'd1);
      chk("hold_data", cdb_data, e.data);
      chk("hold_tag", 32'(cdb_tag), 32'(e.tag));
      chk("hold_iss_ready", 32'(iss_ready), 32'd0);
    end
    cdb_ready = 1'b1;
    @(posedge clk);
    #1 cdb_ready = 1'b0;
    @(negedge clk);
    chk("cdb_valid_drop", 32'(cdb_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_add", 32'(mem_add), 32'd0);
    chk("rst_mem_dw", mem_dw, 32'd0);
    chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    chk("rst_cdb_data", cdb_data, 32'd0);
    chk("rst_cdb_exc", 32'(cdb_exc), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SW then sub-word and sign/zero-extended loads
    run_op(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 4'h3, 32'h0, 1'b0, 1, 0);
    chk("mem_104_sw", mem[65], 32'hDEADBEEF);
    run_op(1'b0, 3'b000, 32'h100, 32'h7, 32'h0, 4'h5, 32'hFFFFFFDE, 1'b0, 0, 0);
    run_op(1'b0, 3'b100, 32'h100, 32'h7, 32'h0, 4'h6, 32'h000000DE, 1'b0, 0, 0);
    run_op(1'b0, 3'b101, 32'h100, 32'h4, 32'h0, 4'h7, 32'h0000BEEF, 1'b0, 0, 0);
    run_op(1'b0, 3'b001, 32'h100, 32'h6, 32'h0, 4'h8, 32'hFFFFDEAD, 1'b0, 0, 0);
    run_op(1'b0, 3'b010, 32'h108, 32'hFFFFFFFC, 32'h0, 4'h9, 32'hDEADBEEF, 1'b0, 0, 0);
    run_op(1'b0, 3'b010, 32'hFFFFFC00, 32'h104, 32'h0, 4'hA, 32'hDEADBEEF, 1'b0, 0, 0);

    run_op(1'b1, 3'b000, 32'h100, 32'h5, 32'hFFFFFF55, 4'hB, 32'h0, 1'b0, 1, 0);
    chk("mem_104_sb", mem[65], 32'hDEAD55EF);
    run_op(1'b1, 3'b001, 32'h106, 32'h0, 32'h00001234, 4'hC, 32'h0, 1'b0, 1, 0);
    chk("mem_104_sh", mem[65], 32'h123455EF);

    // Backpressure on the CDB for 5 cycles
    run_op(1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 4'hD, 32'h123455EF, 1'b0, 0, 5);
    run_op(1'b0, 3'b011, 32'h104, 32'h0, 32'h0, 4'hE, 32'h123455EF, 1'b0, 0, 0);

    run_op(1'b1, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 4'h1, 32'h0, 1'b0, 1, 0);
    chk("mem_100_sw", mem[64], 32'h0BADF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    run_op(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 4'h2, 32'h0, 1'b1, 0, 0);
    run_op(1'b0, 3'b001, 32'h107, 32'h0, 32'h0, 4'h4, 32'h0, 1'b1, 0, 0);
    run_op(1'b1, 3'b001, 32'h100, 32'h1, 32'h0000AAAA, 4'hF, 32'h0, 1'b1, 0, 0);
    chk("mem_100_sh_mis", mem[64], 32'h0BADF00D);
`else
    run_op(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 4'h2, 32'h0BADF00D, 1'b0, 0, 0);
    run_op(1'b0, 3'b001, 32'h107, 32'h0, 32'h0, 4'h4, 32'h00001234, 1'b0, 0, 0);
    run_op(1'b1, 3'b001, 32'h100, 32'h1, 32'h0000AAAA, 4'hF, 32'h0, 1'b0, 1, 0);
    chk("mem_100_sh_mis", mem[64], 32'h0BADAAAA);
`endif

    // Flush during EXEC of a store: no write, no broadcast
    @(negedge clk);
    iss_valid = 1'b1; iss_store = 1'b1; iss_funct3 = 3'b010;
    iss_base = 32'h100; iss_imm = 32'h4; iss_data = 32'hCAFEF00D; iss_tag = 4'h6;
    @(posedge clk);
    #1 iss_valid = 1'b0;
    flush = 1'b1;
    #1 chk("flush_exec_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("flush_iss_ready", 32'(iss_ready), 32'd1);
    @(negedge clk);
    chk("flush_cdb_valid2", 32'(cdb_valid), 32'd0);
    chk("flush_mem_104", mem[65], 32'h123455EF);

    // Flush in IDLE blocks acceptance that cycle
    flush = 1'b1;
    iss_valid = 1'b1; iss_store = 1'b0;
    #1 chk("flush_idle_ready", 32'(iss_ready), 32'd0);
    @(posedge clk);
    #1 begin flush = 1'b0; iss_valid = 1'b0; end
    @(negedge clk);
    chk("flush_idle_not_taken", 32'(iss_ready), 32'd1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
